// File: rtl/uart_reg_engine_pkg.sv
// uart_reg_engine_pkg: shared opcodes, status codes, FSM state type and helpers
//   for the UART register engine and its response serialiser.
package uart_reg_engine_pkg;

    localparam logic [7:0] OP_READ  = 8'h01;
    localparam logic [7:0] OP_WRITE = 8'h02;

    localparam logic [7:0] ST_OK      = 8'h00;
    localparam logic [7:0] ST_CSUM    = 8'h01;
    localparam logic [7:0] ST_OPC     = 8'h02;
    localparam logic [7:0] ST_TIMEOUT = 8'h03;

    localparam logic [7:0] DEF_CMD_SYNC = 8'hA5;
    localparam logic [7:0] DEF_RSP_SYNC = 8'h5A;

    typedef enum logic [2:0] {
        S_HUNT, S_OPC, S_ADDR, S_DATA, S_CSUM, S_BUS, S_RSP
    } state_t;

    // XOR of all four bytes; narrower values are zero-extended by the caller.
    function automatic logic [7:0] xor_bytes(input logic [31:0] v);
        return v[7:0] ^ v[15:8] ^ v[23:16] ^ v[31:24];
    endfunction

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return &v ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/uart_frame_tx_ser.sv
// uart_frame_tx_ser: serialises one response frame (sync, status, data, checksum)
//   clk, rst        : clock, synchronous active-high reset
//   start           : one-cycle load of status/data/with_data
//   status, data    : response contents; data is sent big-endian when with_data=1
//   tx_valid/ready  : byte handshake towards the TX FIFO, tx_data held until taken
//   done            : high in the cycle the final checksum byte is accepted
module uart_frame_tx_ser
    import uart_reg_engine_pkg::*;
#(
    parameter int unsigned DATA_BYTES = 1,
    parameter logic [7:0]  RSP_SYNC   = DEF_RSP_SYNC
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic [7:0]              status,
    input  logic [8*DATA_BYTES-1:0] data,
    input  logic                    with_data,
    input  logic                    tx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    output logic                    done
);
    localparam int DW = 8 * DATA_BYTES;

    logic [2:0]    idx;
    logic [2:0]    nxt;
    logic [2:0]    last;
    logic [DW-1:0] sh;
    logic [7:0]    st;
    logic [7:0]    cs;
    logic          wd;

    // Byte positions: 0 sync, 1 status, 2.. data, last checksum.
    assign nxt  = idx + 3'd1;
    assign last = wd ? 3'(DATA_BYTES + 2) : 3'd2;
    assign done = tx_valid && tx_ready && idx == last;

    always_ff @(posedge clk) begin
        if (rst) begin
            tx_valid <= 1'b0;
            tx_data  <= '0;
            idx      <= '0;
            sh       <= '0;
            st       <= '0;
            cs       <= '0;
            wd       <= 1'b0;
        end else if (start) begin
            tx_valid <= 1'b1;
            tx_data  <= RSP_SYNC;
            idx      <= '0;
            sh       <= data;
            st       <= status;
            wd       <= with_data;
            cs       <= status ^ (with_data ? xor_bytes(32'(data)) : 8'h00);
        end else if (tx_valid && tx_ready) begin
            idx <= nxt;
            if (done) begin
                tx_valid <= 1'b0;
            end else if (nxt == 3'd1) begin
                tx_data <= st;
            end else if (nxt == last) begin
                tx_data <= cs;
            end else begin
                tx_data <= sh[DW-1 -: 8];
                sh      <= sh << 8;
            end
        end
    end

endmodule

// File: rtl/uart_reg_engine.sv
// uart_reg_engine: parses framed UART commands, runs one bus access, returns a framed response
//   clk, rst                 : clock, synchronous active-high reset
//   rx_valid/rx_data/rx_ready: command byte stream from the RX FIFO
//   tx_valid/tx_data/tx_ready: response byte stream to the TX FIFO
//   bus_*                    : req/ack register bus, bus_ack is a single-cycle completion
//   busy                     : high whenever not hunting for a sync byte
//   err_count                : saturating count of non-OK responses plus RX timeouts
module uart_reg_engine
    import uart_reg_engine_pkg::*;
#(
    parameter int unsigned ADDR_BYTES  = 1,
    parameter int unsigned DATA_BYTES  = 1,
    parameter logic [7:0]  CMD_SYNC    = DEF_CMD_SYNC,
    parameter logic [7:0]  RSP_SYNC    = DEF_RSP_SYNC,
    parameter int unsigned RX_TIMEOUT  = 100000,
    parameter int unsigned BUS_TIMEOUT = 255
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    rx_valid,
    input  logic [7:0]              rx_data,
    output logic                    rx_ready,
    output logic                    tx_valid,
    output logic [7:0]              tx_data,
    input  logic                    tx_ready,
    output logic                    bus_req,
    output logic                    bus_we,
    output logic [8*ADDR_BYTES-1:0] bus_addr,
    output logic [8*DATA_BYTES-1:0] bus_wdata,
    input  logic                    bus_ack,
    input  logic [8*DATA_BYTES-1:0] bus_rdata,
    output logic                    busy,
    output logic [15:0]             err_count
);
    localparam int AW  = 8 * ADDR_BYTES;
    localparam int DW  = 8 * DATA_BYTES;
    localparam int RTW = $clog2(RX_TIMEOUT + 1);
    localparam int BTW = $clog2(BUS_TIMEOUT + 1);

    state_t         state;
    logic [1:0]     cnt;
    logic [7:0]     opc;
    logic [7:0]     csum;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  wdata;
    logic [RTW-1:0] rx_tmr;
    logic [BTW-1:0] bus_tmr;
    logic [7:0]     rsp_status;
    logic [DW-1:0]  rsp_data;
    logic           rsp_wd;
    logic           start;
    logic           done;
    logic           accept;
    logic           in_frame;
    logic           bad_csum;

    assign in_frame = state inside {S_OPC, S_ADDR, S_DATA, S_CSUM};
    assign rx_ready = !rst && (state == S_HUNT || in_frame);
    assign accept   = rx_valid && rx_ready;
    assign busy     = state != S_HUNT;
    assign bad_csum = rx_data != csum;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_HUNT;
            cnt        <= '0;
            opc        <= '0;
            csum       <= '0;
            addr       <= '0;
            wdata      <= '0;
            rx_tmr     <= '0;
            bus_tmr    <= '0;
            bus_req    <= 1'b0;
            bus_we     <= 1'b0;
            bus_addr   <= '0;
            bus_wdata  <= '0;
            rsp_status <= '0;
            rsp_data   <= '0;
            rsp_wd     <= 1'b0;
            start      <= 1'b0;
            err_count  <= '0;
        end else begin
            start  <= 1'b0;
            rx_tmr <= accept ? '0 : rx_tmr + 1'b1;
            case (state)
                S_HUNT: begin
                    rx_tmr <= '0;
                    if (accept && rx_data == CMD_SYNC) state <= S_OPC;
                end
                S_OPC: if (accept) begin
                    opc   <= rx_data;
                    csum  <= rx_data;
                    cnt   <= '0;
                    state <= S_ADDR;
                end
                S_ADDR: if (accept) begin
                    addr <= AW'({addr, rx_data});
                    csum <= csum ^ rx_data;
                    cnt  <= cnt + 2'd1;
                    if (cnt == 2'(ADDR_BYTES - 1)) begin
                        cnt   <= '0;
                        state <= opc == OP_WRITE ? S_DATA : S_CSUM;
                    end
                end
                S_DATA: if (accept) begin
                    wdata <= DW'({wdata, rx_data});
                    csum  <= csum ^ rx_data;
                    cnt   <= cnt + 2'd1;
                    if (cnt == 2'(DATA_BYTES - 1)) begin
                        cnt   <= '0;
                        state <= S_CSUM;
                    end
                end
                S_CSUM: if (accept) begin
                    if (bad_csum || (opc != OP_READ && opc != OP_WRITE)) begin
                        rsp_status <= bad_csum ? ST_CSUM : ST_OPC;
                        rsp_wd     <= 1'b0;
                        start      <= 1'b1;
                        err_count  <= sat_inc(err_count);
                        state      <= S_RSP;
                    end else begin
                        bus_req   <= 1'b1;
                        bus_we    <= opc == OP_WRITE;
                        bus_addr  <= addr;
                        bus_wdata <= wdata;
                        bus_tmr   <= '0;
                        state     <= S_BUS;
                    end
                end
                S_BUS: begin
                    bus_tmr <= bus_tmr + 1'b1;
                    if (bus_ack || bus_tmr == BTW'(BUS_TIMEOUT - 1)) begin
                        bus_req    <= 1'b0;
                        rsp_status <= bus_ack ? ST_OK : ST_TIMEOUT;
                        rsp_data   <= bus_ack ? bus_rdata : '0;
                        rsp_wd     <= opc == OP_READ;
                        start      <= 1'b1;
                        state      <= S_RSP;
                        if (!bus_ack) err_count <= sat_inc(err_count);
                    end
                end
                S_RSP: if (done) state <= S_HUNT;
                default: state <= S_HUNT;
            endcase
            // Abandon a stalled frame silently; only the error counter records it.
            if (in_frame && !accept && rx_tmr == RTW'(RX_TIMEOUT - 1)) begin
                state     <= S_HUNT;
                err_count <= sat_inc(err_count);
            end
        end
    end

    uart_frame_tx_ser #(
        .DATA_BYTES(DATA_BYTES),
        .RSP_SYNC  (RSP_SYNC)
    ) u_ser (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .status   (rsp_status),
        .data     (rsp_data),
        .with_data(rsp_wd),
        .tx_ready (tx_ready),
        .tx_valid (tx_valid),
        .tx_data  (tx_data),
        .done     (done)
    );

endmodule

// File: doc/uart_reg_engine.md
Name: uart_reg_engine

Overview:
Parametrised successor to the fixed 8-bit parser/dispatcher path of the UART register access system. It consumes the received UART byte stream and hunts for framed commands with configurable address and data widths. It checks an XOR checksum, runs one register access on a generic req/ack bus with a timeout, and emits a framed response byte stream towards the transmit path. It sits between the RX byte FIFO and the TX response FIFO, replacing the separate parser, command FIFO and dispatcher.

Parameters:
ADDR_BYTES, 1, address bytes per frame (1..4), big-endian on the wire
DATA_BYTES, 1, data bytes per frame (1..4), big-endian on the wire
CMD_SYNC, 8'hA5, command frame start byte
RSP_SYNC, 8'h5A, response frame start byte
RX_TIMEOUT, 100000, maximum clk cycles between bytes inside a frame
BUS_TIMEOUT, 255, maximum clk cycles from bus_req to bus_ack

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
rx_valid  in  1  RX byte available
rx_data  in  8  RX byte
rx_ready  out  1  byte consumed when rx_valid&&rx_ready
tx_valid  out  1  response byte valid
tx_data  out  8  response byte
tx_ready  in  1  byte taken when tx_valid&&tx_ready
bus_req  out  1  access request
bus_we  out  1  1=write, 0=read
bus_addr  out  8*ADDR_BYTES  access address
bus_wdata  out  8*DATA_BYTES  write data
bus_ack  in  1  single-cycle completion
bus_rdata  in  8*DATA_BYTES  read data, valid with bus_ack
busy  out  1  high in every state except HUNT
err_count  out  16  saturating count of non-OK responses plus RX timeouts

Behaviour:
- Reset: one clock, synchronous, active-high, as already decided. All outputs are 0 after reset (rx_ready=0 during rst), state=HUNT, err_count=0. Reset mid-frame or mid-access drops bus_req and tx_valid on the next edge with no partial response.
- Command frame: CMD_SYNC, OPC, ADDR[ADDR_BYTES], DATA[DATA_BYTES] (OPC=8'h02 only), CSUM.
- CSUM is the XOR of every byte after the sync byte, excluding CSUM itself.
- Opcodes: 8'h01 read, 8'h02 write. Any other opcode is parsed as read-length.
- States: HUNT, OPC, ADDR, DATA, CSUM, BUS, RSP.
- HUNT: rx_ready=1. Bytes other than CMD_SYNC are discarded; CMD_SYNC moves to OPC.
- OPC/ADDR/DATA/CSUM: rx_ready=1, one byte per handshake. A byte counter tracks ADDR/DATA position, and address/data shift in MSB first.
- BUS, RSP: rx_ready=0, so no buffering and back-pressure falls on the upstream FIFO.
- Inter-byte timeout: a counter runs in OPC..CSUM, cleared on each accepted byte. When it reaches RX_TIMEOUT, go to HUNT, increment err_count, send no response.
- At CSUM byte, status is chosen in priority order:
  - checksum mismatch -> 8'h01
  - bad opcode -> 8'h02
  - otherwise go to BUS.
  - Error statuses go directly to RSP with no bus activity.
- BUS:
  - bus_req is asserted the cycle after CSUM is accepted, with bus_we/bus_addr/bus_wdata stable, and held until bus_ack or timeout.
  - bus_ack samples bus_rdata and gives status 8'h00.
  - If the cycle counter reaches BUS_TIMEOUT: status 8'h03, read data forced to 0.
  - bus_req drops the cycle after ack or timeout. bus_ack while bus_req=0 is ignored.
- RSP byte sequence:
  - RSP_SYNC
  - STATUS
  - DATA[DATA_BYTES], only for opcode 8'h01 with status 00 or 03
  - RCSUM = XOR of STATUS and DATA bytes
- RSP handshake: tx_valid stays high and tx_data stays stable until tx_ready. After the last byte is accepted, go to HUNT the next cycle.
- Throughput: the first response byte is presented the cycle after entering RSP.
- err_count saturates at 16'hFFFF and is incremented once per non-00 status.

Decomposition:
- Shared package (extend cmd_pkg):
  - opcode constants OP_READ/OP_WRITE
  - status constants ST_OK/ST_CSUM/ST_OPC/ST_TIMEOUT
  - state enum type
  - sync byte defaults
- One natural sub-module, uart_frame_tx_ser: loads status and data, then serialises the response with the valid/ready handshake and computes RCSUM.

Test Plan:
- Write (ADDR_BYTES=DATA_BYTES=1): RX A5 02 10 3C 2E, bus_ack after 3 cycles -> one bus_req with we=1, addr=10, wdata=3C; TX 5A 00 00.
- Read: RX A5 01 10 11, bus_rdata=3C with ack -> TX 5A 00 3C 3C; tx_ready toggled 50% still gives exact order with no dropped bytes.
- Bad checksum: RX A5 01 10 FF -> no bus_req; TX 5A 01 01; err_count=1.
- Bad opcode: RX A5 07 10 17 -> TX 5A 02 02. Then bus timeout: RX A5 01 20 21 with bus_ack never -> bus_req high exactly BUS_TIMEOUT cycles; TX 5A 03 00 03.
- RX timeout and resync: RX 33 A5 01 then idle RX_TIMEOUT cycles -> no TX, err_count+1. The following A5 01 10 11 is served normally.
- Wide config (ADDR_BYTES=2, DATA_BYTES=4): write A5 02 12 34 DE AD BE EF csum -> addr=1234, wdata=DEADBEEF. Also assert rst mid-BUS -> bus_req=0 and tx_valid=0 next cycle.
